// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared constants and state encoding for the packed-BCD to
//                binary converter and its helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_pkg;

    localparam int         DIGIT_W       = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd2bin_state_t;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_mac10.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mac10
//  Description : Combinational multiply-by-ten-and-add step, acc*10 + digit,
//                built from two shifts and two adds. Result wraps at ACC_W.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int ACC_W = 11
) (
    input  logic [ACC_W-1:0]   acc_i,
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [ACC_W-1:0]   mac_o
);

    // acc*8 + acc*2 + digit; carries out of the top bit are dropped
    assign mac_o = (acc_i << 3) + (acc_i << 1) + ACC_W'(digit_i);

endmodule : bcd_mac10
`default_nettype wire

// File: rtl/bcd_to_binary.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_binary
//  Description : Sequential packed-BCD to binary converter. Latches DIGITS
//                BCD digits on an input valid/ready handshake, folds them in
//                MSD first (one digit per clock) and presents the binary
//                value on an output valid/ready handshake.
//  Options     : define BCD_CHECK_EN to flag nibbles above 9 on out_err;
//                without it out_err is tied low and nibbles 10..15 are
//                weighted as their plain value.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*DIGITS-1:0]    bcd_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BIN_W-1:0]       out_bin,
    output logic                   out_err
);

    localparam int ACC_W = BIN_W + 4;
    localparam int IN_W  = DIGIT_W * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    bcd2bin_state_t     state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [IN_W-1:0]    shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;
    logic [BIN_W-1:0]   out_bin_q;
    logic [DIGIT_W-1:0] top_nibble;

    // The digit being folded in this cycle is always the top nibble
    assign top_nibble = shift_q[IN_W-1 -: DIGIT_W];

    bcd_mac10 #(
        .ACC_W   (ACC_W)
    ) u_mac10 (
        .acc_i   (acc_q),
        .digit_i (top_nibble),
        .mac_o   (acc_d)
    );

`ifdef BCD_CHECK_EN
    logic err_q;
    logic out_err_q;
    logic bad_nibble;

    // Non-decimal nibble in the digit currently being consumed
    assign bad_nibble = (top_nibble > BCD_MAX_DIGIT);
`endif

    // Converter FSM with digit counter, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
`ifdef BCD_CHECK_EN
            err_q       <= 1'b0;
            out_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shift_q <= bcd_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
`ifdef BCD_CHECK_EN
                        err_q   <= 1'b0;
`endif
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    acc_q   <= acc_d;
                    shift_q <= shift_q << DIGIT_W;
                    cnt_q   <= cnt_q + CNT_W'(1);
`ifdef BCD_CHECK_EN
                    if (bad_nibble) begin
                        err_q <= 1'b1;
                    end
`endif
                    if (cnt_q == LAST_CNT) begin
                        // Final digit: publish the wrapped result directly
                        out_valid_q <= 1'b1;
                        out_bin_q   <= acc_d[BIN_W-1:0];
`ifdef BCD_CHECK_EN
                        out_err_q   <= err_q | bad_nibble;
`endif
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;

`ifdef BCD_CHECK_EN
    assign out_err   = out_valid_q & out_err_q;
`else
    assign out_err   = 1'b0;
`endif

endmodule : bcd_to_binary
`default_nettype wire

// File: tb/tb_bcd_to_binary.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_to_binary
//  Description : Self-checking bench for bcd_to_binary (DIGITS=2, BIN_W=7)
//                using an expected-result queue filled on accept and drained
//                on output handshakes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_to_binary;

    localparam int DIGITS = 2;
    localparam int BIN_W  = 7;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       bcd_in;
    logic             out_valid;
    logic             out_ready;
    logic [BIN_W-1:0] out_bin;
    logic             out_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [BIN_W-1:0] exp_bin_q[$];
    logic             exp_err_q[$];

    bcd_to_binary #(
        .DIGITS    (DIGITS),
        .BIN_W     (BIN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal fold of the two nibbles, wrapped to BIN_W bits
    function automatic logic [BIN_W-1:0] model_bin(input logic [7:0] v);
        int acc;
        acc = int'(v[7:4]) * 10 + int'(v[3:0]);
        return BIN_W'(acc % 128);
    endfunction

    function automatic logic model_err(input logic [7:0] v);
`ifdef BCD_CHECK_EN
        return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
`else
        return 1'b0 & v[0];
`endif
    endfunction

    // Present a request; push its expectation the cycle it will be accepted.
    // Called and returns just after a falling edge.
    task automatic send(input logic [7:0] v, input bit keep_valid);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        bcd_in   = v;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) begin
                exp_bin_q.push_back(model_bin(v));
                exp_err_q.push_back(model_err(v));
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        if (!keep_valid) in_valid = 1'b0;
    endtask

    // Wait for an output handshake and compare against the queue head
    task automatic recv(input string name);
        bit               done;
        logic [BIN_W-1:0] eb;
        logic             ee;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (out_valid && out_ready) begin
                n_tests++;
                if (exp_bin_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_unexpected: got out_bin=%0d with empty queue", name, out_bin);
                end else begin
                    eb = exp_bin_q.pop_front();
                    ee = exp_err_q.pop_front();
                    if (out_bin !== eb || out_err !== ee) begin
                        n_fail++;
                        $display("FAIL %s: out_bin=%0d out_err=%0b required %0d/%0b",
                                 name, out_bin, out_err, eb, ee);
                    end
                end
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: out_valid=%0b required 1", name, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bin !== '0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: rdy=%0b vld=%0b bin=%0d err=%0b required 1/0/0/0",
                     in_ready, out_valid, out_bin, out_err);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(8'h15, 1'b0);
        // Now between accept edge k and k+1: valid must rise only after k+2
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_k1: out_valid=%0b required 0", out_valid);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_k2: out_valid=%0b required 0", out_valid);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_bin !== 7'd15) begin
            n_fail++;
            $display("FAIL latency_k3: out_valid=%0b out_bin=%0d required 1/15", out_valid, out_bin);
        end
        recv("basic_15");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(8'h99, 1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_bin !== 7'd99 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d: vld=%0b bin=%0d rdy=%0b required 1/99/0",
                         i, out_valid, out_bin, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        recv("hold_99");
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        fork
            begin
                send(8'h00, 1'b1);
                send(8'h42, 1'b0);
            end
            begin
                recv("b2b_00");
                recv("b2b_42");
            end
        join
        repeat (6) begin
            n_tests++;
            if (out_valid !== 1'b0 || exp_bin_q.size() != 0) begin
                n_fail++;
                $display("FAIL b2b_extra: out_valid=%0b queue=%0d required 0/0",
                         out_valid, exp_bin_q.size());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bad_nibble();
        out_ready = 1'b1;
        send(8'h1A, 1'b0);
        recv("nibble_1A");
        send(8'h07, 1'b0);
        recv("nibble_07");
    endtask

    task automatic test_reset_mid_conv();
        out_ready = 1'b1;
        send(8'h37, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_bin_q.delete();
        exp_err_q.delete();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: rdy=%0b vld=%0b required 1/0", in_ready, out_valid);
        end
        repeat (4) begin
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_quiet: out_valid=%0b required 0", out_valid);
            end
            @(negedge clk);
        end
        send(8'h08, 1'b0);
        recv("after_rst_08");
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        bcd_in    = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_bad_nibble();
        test_reset_mid_conv();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_bcd_to_binary
`default_nettype wire
